// File: rtl/txn_sequencer.sv
// txn_sequencer: issues a run of tagged requests on a fixed 64-byte stride and
// tracks their in-order responses, flagging tag mismatches and response timeouts.
module txn_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                num_txn,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [ADDR_W-1:0]          req_addr,
  output logic [$clog2(MAX_OUT)-1:0] req_id,
  input  logic                       resp_valid,
  input  logic [$clog2(MAX_OUT)-1:0] resp_id,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [4:0]                 outstanding
);
  localparam int ID_W = $clog2(MAX_OUT);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [4:0]        MAX_OUT_C = 5'(MAX_OUT);
  localparam logic [TW-1:0]     TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(7'd64);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]        state_r, state_s;
  logic [15:0]       num_r, num_s;
  logic [15:0]       iss_r, iss_s;
  logic [15:0]       rcv_r, rcv_s;
  logic [4:0]        out_r, out_s;
  logic [TW-1:0]     tmo_r, tmo_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              hs_s, rsp_s, bad_id_s;

  assign req_addr    = addr_r;
  assign req_id      = iss_r[ID_W-1:0];
  assign outstanding = out_r;

  // Next-state and counter update; responses are only honoured while a run is active and something is in flight.
  always_comb begin
    state_s  = state_r;
    num_s    = num_r;
    iss_s    = iss_r;
    rcv_s    = rcv_r;
    out_s    = out_r;
    tmo_s    = tmo_r;
    addr_s   = addr_r;
    hs_s     = req_valid && req_ready;
    rsp_s    = busy && resp_valid && (out_r != 5'd0);
    bad_id_s = rsp_s && (resp_id != rcv_r[ID_W-1:0]);
    case (state_r)
      S_ISSUE, S_DRAIN: begin
        if (hs_s) begin
          iss_s  = iss_r + 16'd1;
          addr_s = addr_r + STRIDE;
        end else begin
          iss_s  = iss_r;
          addr_s = addr_r;
        end
        if (rsp_s) rcv_s = rcv_r + 16'd1;
        else       rcv_s = rcv_r;
        if (hs_s && !rsp_s)      out_s = out_r + 5'd1;
        else if (rsp_s && !hs_s) out_s = out_r - 5'd1;
        else                     out_s = out_r;
        // Idle-response watchdog: only runs while something is waiting for an answer.
        if ((out_r != 5'd0) && !resp_valid) tmo_s = tmo_r + TW'(1'b1);
        else                                tmo_s = '0;
        if (bad_id_s || (tmo_s == TIMEOUT_C))              state_s = S_ERR;
        else if ((state_r == S_DRAIN) && (rcv_s == num_r)) state_s = S_FIN;
        else if (iss_s == num_r)                           state_s = S_DRAIN;
        else                                               state_s = state_r;
      end
      S_IDLE, S_FIN, S_ERR: begin
        if (start) begin
          num_s   = num_txn;
          iss_s   = 16'd0;
          rcv_s   = 16'd0;
          out_s   = 5'd0;
          tmo_s   = '0;
          addr_s  = base_addr;
          state_s = (num_txn != 16'd0) ? S_ISSUE : S_FIN;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, counters and all status outputs are registered from the next-state values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      num_r     <= 16'd0;
      iss_r     <= 16'd0;
      rcv_r     <= 16'd0;
      out_r     <= 5'd0;
      tmo_r     <= '0;
      addr_r    <= '0;
      req_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      num_r     <= num_s;
      iss_r     <= iss_s;
      rcv_r     <= rcv_s;
      out_r     <= out_s;
      tmo_r     <= tmo_s;
      addr_r    <= addr_s;
      req_valid <= (state_s == S_ISSUE) && (iss_s < num_s) && (out_s < MAX_OUT_C);
      busy      <= (state_s == S_ISSUE) || (state_s == S_DRAIN);
      done      <= (state_s == S_FIN);
      err       <= (state_s == S_ERR);
    end
  end
endmodule

// File: doc/txn_sequencer.md
TXN_SEQUENCER -- requirements
Module: txn_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum outstanding requests (power of 2, 2..16).
REQ-003 SHALL have parameter TIMEOUT, default 1024, idle-response cycle limit.
REQ-004 SHALL have port: clock  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  one-cycle pulse, begins a run; sampled only in IDLE or DONE.
REQ-007 SHALL have port: num_txn  input  16  request count for the run; sampled with start.
REQ-008 SHALL have port: base_addr  input  ADDR_W  first request address; sampled with start.
REQ-009 SHALL have port: req_valid  output  1  request valid.
REQ-010 SHALL have port: req_ready  input  1  downstream accepts the request.
REQ-011 SHALL have port: req_addr  output  ADDR_W  request address.
REQ-012 SHALL have port: req_id  output  log2(MAX_OUT)  request tag.
REQ-013 SHALL have port: resp_valid  input  1  one response per cycle, in issue order.
REQ-014 SHALL have port: resp_id  input  log2(MAX_OUT)  tag of the response.
REQ-015 SHALL have port: busy  output  1  run in progress.
REQ-016 SHALL have port: done  output  1  run completed; level, held until next start or reset.
REQ-017 SHALL have port: err  output  1  timeout or tag mismatch; level, held until next start or reset.
REQ-018 SHALL have port: outstanding  output  5  issued but unanswered request count.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN, FIN, ERR.
REQ-020 SHALL go IDLE/FIN/ERR -> ISSUE on start with num_txn>0, latching num_txn and base_addr and clearing all counters, done and err.
REQ-021 SHALL go to FIN the next cycle, with done=1, on start with num_txn=0.
REQ-022 SHALL drive req_valid=1 in ISSUE while issued<num_txn and outstanding<MAX_OUT; otherwise req_valid=0.
REQ-023 SHALL hold req_addr and req_id stable while req_valid=1 and req_ready=0.
REQ-024 SHALL drive req_addr = base_addr + issued*64, truncated to ADDR_W bits, with wrap-around allowed.
REQ-025 SHALL drive req_id = issued mod MAX_OUT.
REQ-026 SHALL increment issued and outstanding on a handshake (req_valid & req_ready).
REQ-027 SHALL decrement outstanding and increment received on resp_valid.
REQ-028 SHALL leave outstanding unchanged on a simultaneous handshake and resp_valid.
REQ-029 SHALL check that resp_id equals received mod MAX_OUT; on mismatch go to ERR with err=1 the next cycle.
REQ-030 SHALL ignore resp_valid while outstanding=0; it SHALL NOT underflow the counter.
REQ-031 SHALL go ISSUE -> DRAIN when issued==num_txn.
REQ-032 SHALL go DRAIN -> FIN when received==num_txn; done asserts in the cycle after the final response.
REQ-033 SHALL count, in ISSUE or DRAIN, consecutive cycles with outstanding>0 and no resp_valid, resetting the count on any response.
REQ-034 SHALL go to ERR with err=1 when that count reaches TIMEOUT.
REQ-035 SHALL drive busy=1 exactly in ISSUE and DRAIN.
REQ-036 SHALL ignore start while busy=1.
REQ-037 SHALL drive req_valid=0 in ERR; later responses SHALL NOT change state.

Reset
REQ-038 SHALL, on reset assertion at any time including mid-run, immediately enter IDLE with req_valid=0, busy=0, done=0, err=0, outstanding=0, and all counters 0.
REQ-039 SHALL drive req_addr=0 and req_id=0 under reset.
REQ-040 SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-041 SHALL verify: start, num_txn=3, base=0x1000, req_ready=1, each response returned 2 cycles after issue -> addresses 0x1000/0x1040/0x1080, ids 0/1/2, done=1 one cycle after the third response.
REQ-042 SHALL verify: num_txn=8, req_ready=1, no responses -> exactly 4 requests issued, outstanding=4, req_valid low; after TIMEOUT cycles, err=1 and busy=0.
REQ-043 SHALL verify: req_ready toggles 0/1 per cycle -> req_addr and req_id stable while stalled; no lost or duplicate requests.
REQ-044 SHALL verify: a response arrives with resp_id=1 when 0 is expected -> err=1 next cycle, req_valid=0 thereafter.
REQ-045 SHALL verify: reset pulse asserted mid-DRAIN -> all outputs 0 in the same cycle; a new start completes normally.
REQ-046 SHALL verify: base=0xFFFFFFC0, num_txn=2 -> addresses 0xFFFFFFC0 then 0x00000000.
